ysyx_25040109_mdu: RTL and testbench
====================================

Name: ysyx_25040109_mdu

Overview:
- Multi-cycle RV32M multiply/divide unit that sequences the M-extension datapath instead of using single-cycle `*`, `/` and `%`.
- Sits beside the EXU ALU. The EXU hands it funct3 plus rs1/rs2 through a valid/ready handshake and stalls until the result returns on a second valid/ready handshake.
- Uses a radix-2 shift-add multiplier and a restoring divider that share one 64-bit working register, sequenced by a 3-state FSM.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  XLEN  rs1 operand.
- in_b  input  XLEN  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  XLEN  result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_result=0, busy=0, counter=0, working regs=0. in_ready=1 after reset, because it is combinational: in_ready = (state==IDLE).
- States: IDLE, CALC, DONE.
- IDLE: on in_valid&&in_ready (cycle T):
  - Latch funct3.
  - Latch magnitudes |a| and |b|. Signed ops (MUL/MULH/DIV/REM take both operands signed; MULHSU takes a signed only) use two's-complement absolute value. Unsigned operands pass unchanged.
  - Latch result-sign flags:
    - mul sign = sa^sb.
    - quotient sign = sa^sb.
    - remainder sign = sa (dividend sign).
  - Clear counter to 0. Next state is CALC.
- Fast paths (decided at T, next state DONE, out_valid high at T+1, no CALC):
  - DIV/DIVU with b==0: result all-ones (0xFFFFFFFF).
  - REM/REMU with b==0: result a (original, unsigned-interpreted bits).
  - DIV with a==0x80000000 and b==0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- CALC: one iteration per cycle; counter increments; after the iteration with counter==XLEN-1 the next state is DONE.
  - CALC therefore occupies T+1..T+32 and out_valid rises at T+33.
  - Multiply: 64-bit product accumulate, shift-add on the LSB of the multiplier.
  - Divide: restoring shift/subtract. The remainder occupies the upper half and the quotient the lower half.
- Entry into DONE loads out_result. The sign fix-up (two's-complement negate when the flag is set) is applied in this same registered write:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: out_valid=1, and out_result is held stable until out_ready. On out_valid&&out_ready the next state is IDLE and out_valid falls the next cycle. in_ready becomes 1 in that next cycle; there is no same-cycle accept in DONE.
- Stability: in_a, in_b and in_funct3 are ignored outside the IDLE handshake; mid-operation changes have no effect.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values and the result is discarded.
- Arithmetic is modulo 2^XLEN. MUL low-word results are identical for signed and unsigned operands.
- Minimum throughput: one op per 34 cycles (normal) or 2 cycles (fast path), with out_ready tied high.

Optional Feature:
- Macro: YSYX_25040109_MDU_FLUSH_EN.
- Defined: adds input port `flush` (1 bit).
  - flush=1 in CALC or DONE forces state=IDLE, out_valid=0 and counter=0 at the next edge; out_result keeps its previous value.
  - In IDLE, flush has priority over in_valid: no request is accepted that cycle.
- Undefined: no `flush` port; an operation always runs to completion.

Test Plan:
- Reset then idle: rst pulse → in_ready=1, out_valid=0, out_result=0, busy=0.
- MUL a=7, b=-3 (0xFFFFFFFD) accepted at T, out_ready=1 → out_valid first high at T+33, result 0xFFFFFFEB. MULHU with the same operands → result 0x00000006.
- DIV a=-20, b=3 → 0xFFFFFFFA (-6). REM same operands → 0xFFFFFFFE (-2). DIVU a=20, b=3 → 6.
- Divide by zero: DIVU a=5, b=0 → out_valid at T+1, result 0xFFFFFFFF. REM a=0x80000001, b=0 → 0x80000001.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at T+1. REM with the same operands → 0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_result stay stable and in_ready stays 0. Toggling in_a during CALC leaves the result unchanged. With FLUSH_EN, flush at T+10 → IDLE at T+11, and no out_valid for that op.

Source files
------------

// File: rtl/ysyx_25040109_mdu.sv
// ysyx_25040109_mdu -- multi-cycle RV32M multiply/divide unit.
//
// A radix-2 shift-add multiplier and a restoring divider share one
// 2*XLEN-bit working register. A three-state FSM (IDLE, CALC, DONE)
// sequences them, with one iteration per clock.
//
// Optional build macro: YSYX_25040109_MDU_FLUSH_EN adds a 'flush' input.
// A flush aborts CALC/DONE back to IDLE and blocks acceptance in IDLE.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             (macro only) abort the current operation
//   in_valid/ready    request handshake; in_ready = (state == IDLE)
//   in_funct3         M-extension funct3 (MUL..REMU)
//   in_a, in_b        rs1 / rs2 operands
//   out_valid/ready   result handshake; out_valid = (state == DONE)
//   out_result        registered result, held while in DONE
//   busy              high in CALC or DONE
module ysyx_25040109_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
`ifdef YSYX_25040109_MDU_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_reg,   state_next;
    logic [2:0]        funct3_reg,  funct3_next;
    logic [XLEN-1:0]   opnd_reg,    opnd_next;     // multiplicand or divisor
    logic              neg_reg,     neg_next;      // result needs negation
    logic [CW-1:0]     counter_reg, counter_next;
    logic [2*XLEN-1:0] work_reg,    work_next;
    logic [XLEN-1:0]   result_reg,  result_next;

    logic flush_w;
`ifdef YSYX_25040109_MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Request decode
    logic            in_is_div, a_signed, b_signed, sa, sb;
    logic            b_zero, div_ovf, fast_in, neg_in;
    logic [XLEN-1:0] abs_a, abs_b, fast_result;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    assign in_is_div = in_funct3[2];
    // Signed a: MUL, MULH, MULHSU, DIV, REM. Signed b: MUL, MULH, DIV, REM.
    assign a_signed  = in_is_div ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
    assign b_signed  = in_is_div ? ~in_funct3[0] : ~in_funct3[1];
    assign sa        = a_signed & in_a[XLEN-1];
    assign sb        = b_signed & in_b[XLEN-1];
    assign abs_a     = sa ? (~in_a + 1'b1) : in_a;
    assign abs_b     = sb ? (~in_b + 1'b1) : in_b;
    // Remainder takes the dividend sign; product and quotient take sa^sb.
    assign neg_in    = (in_is_div & in_funct3[1]) ? sa : (sa ^ sb);

    assign b_zero    = (in_b == '0);
    assign div_ovf   = in_is_div & ~in_funct3[0] & (in_a == XMIN) & (in_b == '1);
    assign fast_in   = in_is_div & (b_zero | div_ovf);
    assign fast_result = b_zero ? (in_funct3[1] ? in_a : '1)
                                : (in_funct3[1] ? '0   : XMIN);

    // Datapath: one iteration of each algorithm
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, step, step_neg, prod;
    logic [XLEN-1:0]   quot_raw, rem_raw, quot_fix, rem_fix, calc_result;

    assign mul_sum  = {1'b0, work_reg[2*XLEN-1:XLEN]}
                    + (work_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, work_reg[XLEN-1:1]};

    // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
    assign rem_sh   = work_reg[2*XLEN-1:XLEN-1];
    assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_reg};
    assign div_step = div_diff[XLEN+1]
                    ? {rem_sh[XLEN-1:0],   work_reg[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], work_reg[XLEN-2:0], 1'b1};

    assign step     = funct3_reg[2] ? div_step : mul_step;
    assign step_neg = ~step + 1'b1;
    assign prod     = neg_reg ? step_neg : step;
    assign quot_raw = step[XLEN-1:0];
    assign rem_raw  = step[2*XLEN-1:XLEN];
    assign quot_fix = neg_reg ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = neg_reg ? (~rem_raw + 1'b1)  : rem_raw;

    always_comb begin
        calc_result = '0;
        if (funct3_reg[2])
            calc_result = funct3_reg[1] ? rem_fix : quot_fix;
        else if (funct3_reg[1:0] == 2'b00)
            calc_result = prod[XLEN-1:0];
        else
            calc_result = prod[2*XLEN-1:XLEN];
    end

    // FSM
    always_comb begin
        state_next   = state_reg;
        funct3_next  = funct3_reg;
        opnd_next    = opnd_reg;
        neg_next     = neg_reg;
        counter_next = counter_reg;
        work_next    = work_reg;
        result_next  = result_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid && !flush_w) begin
                    funct3_next  = in_funct3;
                    neg_next     = neg_in;
                    counter_next = '0;
                    opnd_next    = in_is_div ? abs_b : abs_a;
                    work_next    = {{XLEN{1'b0}}, (in_is_div ? abs_a : abs_b)};
                    if (fast_in) begin
                        result_next = fast_result;
                        state_next  = S_DONE;
                    end else begin
                        state_next  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                counter_next = counter_reg + 1'b1;
                work_next    = step;
                if (counter_reg == CW'(XLEN-1)) begin
                    result_next = calc_result;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort keeps the last delivered result in out_result.
        if (flush_w && state_reg != S_IDLE) begin
            state_next   = S_IDLE;
            counter_next = '0;
            work_next    = work_reg;
            result_next  = result_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            funct3_reg  <= '0;
            opnd_reg    <= '0;
            neg_reg     <= 1'b0;
            counter_reg <= '0;
            work_reg    <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            funct3_reg  <= funct3_next;
            opnd_reg    <= opnd_next;
            neg_reg     <= neg_next;
            counter_reg <= counter_next;
            work_reg    <= work_next;
            result_reg  <= result_next;
        end
    end

    assign in_ready   = (state_reg == S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign busy       = (state_reg != S_IDLE);
    assign out_result = result_reg;

endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
// Directed testbench for ysyx_25040109_mdu: hand-computed RV32M vectors,
// fast-path latency, back-pressure, input stability and mid-op reset.
module tb_ysyx_25040109_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;
`ifdef YSYX_25040109_MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_25040109_mdu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef YSYX_25040109_MDU_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue a request, wait for out_valid, check latency and result, and
    // with out_ready high confirm the return to IDLE one cycle later.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input bit scramble);
        int lat;
        @(negedge clk);
        in_funct3 = f3; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (scramble) begin
                in_a = $urandom; in_b = $urandom; in_funct3 = 3'($urandom_range(7));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, out_result, exp);
        $display("op %s f3=%0d a=%h b=%h -> %h (latency %0d)", tag, f3, a, b, out_result, lat);
        @(posedge clk); #1;
        check({tag, " idle after"}, {30'b0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        // Reset state
        #1;
        check("reset in_ready",  {31'b0, in_ready},  32'h1);
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset busy",      {31'b0, busy},      32'h0);
        check("reset result",    out_result,         32'h0);
        @(negedge clk); rst = 1'b0;

        // Multiply
        do_op("MUL 7*-3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0);
        do_op("MULHU 7*fd",  3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 32, 0);
        do_op("MULH 7*-3",   3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32, 0);
        do_op("MULHSU -1*2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32, 0);
        do_op("MULH min*min",3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32, 0);
        do_op("MUL -5*-6",   3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 32, 0);
        // Divide
        do_op("DIV -20/3",   3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 32, 0);
        do_op("REM -20%3",   3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 32, 0);
        do_op("DIVU 20/3",   3'b101, 32'd20,       32'd3,        32'h00000006, 32, 0);
        do_op("REMU 20%3",   3'b111, 32'd20,       32'd3,        32'h00000002, 32, 0);
        do_op("DIVU max/1",  3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32, 0);
        do_op("DIV 7/-2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32, 0);
        do_op("REM 7%-2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32, 0);
        // Fast paths
        do_op("DIVU 5/0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0);
        do_op("REM x/0",     3'b110, 32'h80000001, 32'd0,        32'h80000001, 0, 0);
        do_op("DIV ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        do_op("REM ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);
        // Inputs scrambled during CALC must not affect the result
        do_op("DIVU scramble", 3'b101, 32'd100,    32'd7,        32'd14,       32, 1);

        // Back-pressure in DONE
        out_ready = 1'b0;
        do_op_bp();

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        in_funct3 = 3'b101; in_a = 32'd1000; in_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midcalc busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst in_ready",  {31'b0, in_ready},  32'h1);
        check("midrst busy",      {31'b0, busy},      32'h0);
        check("midrst result",    out_result,         32'h0);
        $display("op reset mid-CALC");
        @(negedge clk); rst = 1'b0;
        do_op("REMU after rst", 3'b111, 32'd100, 32'd7, 32'd2, 32, 0);

`ifdef YSYX_25040109_MDU_FLUSH_EN
        begin
            int seen;
            @(negedge clk);
            in_funct3 = 3'b000; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush in_ready", {31'b0, in_ready}, 32'h1);
            check("flush result kept", out_result, 32'd2);
            seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("flush no out_valid", 32'(seen), 32'h0);
            $display("op flush mid-CALC");
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic do_op_bp();
        int lat;
        @(negedge clk);
        in_funct3 = 3'b000; in_a = 32'd7; in_b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd32);
        check("bp result", out_result, 32'hFFFFFFEB);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", {31'b0, out_valid}, 32'h1);
            check("bp held",      out_result,         32'hFFFFFFEB);
            check("bp in_ready",  {31'b0, in_ready},  32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {30'b0, out_valid, in_ready}, 32'h1);
        $display("op back-pressure MUL 7*-3 held 10 cycles -> %h", out_result);
    endtask

endmodule
